// File: rtl/prbs7_ber_ctrl_if.sv
// Control/status bundle between a BER test sequencer (master) and prbs7_ber_ctrl (slave).
interface prbs7_ber_ctrl_if #(
  parameter int WIN_W = 32
);
  logic             start;
  logic             abort;
  logic [WIN_W-1:0] window;
  logic [6:0]       err_cnt;
  logic             busy;
  logic             locked;
  logic             done;
  logic             fail;
  logic [2:0]       state;
  logic [39:0]      err_total;
  logic [WIN_W-1:0] words_done;

  modport master (
    output start, abort, window, err_cnt,
    input  busy, locked, done, fail, state, err_total, words_done
  );

  modport slave (
    input  start, abort, window, err_cnt,
    output busy, locked, done, fail, state, err_total, words_done
  );
endinterface

// File: rtl/prbs7_ber_ctrl.sv
// PRBS7 bit-error-rate test controller: settle, acquire lock, then accumulate checker errors over a window.
// Optional loss-of-lock abort during measurement is enabled by defining PRBS7_BER_LOSS_DETECT_EN.
module prbs7_ber_ctrl #(
  parameter int WIN_W        = 32,
  parameter int PIPE_LAT     = 7,
  parameter int LOCK_WORDS   = 16,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            reset_n,
  prbs7_ber_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_LOCK    = 3'd2,
    ST_MEASURE = 3'd3,
    ST_DONE    = 3'd4,
    ST_FAIL    = 3'd5
  } state_t;

  localparam int SET_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int RUN_W = $clog2(LOCK_WORDS + 1);
  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);

  // The checker can report at most 64 errors per 64-bit word; larger codes are treated as a full word.
  function automatic logic [6:0] clamp_err(input logic [6:0] e);
    if (e > 7'd64) begin
      clamp_err = 7'd64;
    end else begin
      clamp_err = e;
    end
  endfunction

  function automatic logic [39:0] sat_add(input logic [39:0] a, input logic [6:0] b);
    logic [40:0] s;
    s = {1'b0, a} + {34'd0, b};
    if (s[40]) begin
      sat_add = {40{1'b1}};
    end else begin
      sat_add = s[39:0];
    end
  endfunction

  state_t           state_q, state_d;
  logic [SET_W-1:0] set_cnt_q, set_cnt_d;
  logic [RUN_W-1:0] run_q, run_d, run_inc;
  logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
  logic [WIN_W-1:0] win_q, win_d;
  logic [39:0]      tot_q, tot_d;
  logic [WIN_W-1:0] wd_q, wd_d, wd_inc;
  logic             busy_q, busy_d;
  logic             locked_q, locked_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;

  // Next-state and counter update; abort overrides every other transition.
  always_comb begin
    state_d   = state_q;
    set_cnt_d = set_cnt_q;
    run_d     = run_q;
    tmo_d     = tmo_q;
    win_d     = win_q;
    tot_d     = tot_q;
    wd_d      = wd_q;
    run_inc   = '0;
    tmo_inc   = tmo_q + TMO_W'(1);
    wd_inc    = wd_q + WIN_W'(1);

    if (bus.abort) begin
      state_d   = ST_IDLE;
      set_cnt_d = '0;
      run_d     = '0;
      tmo_d     = '0;
      win_d     = '0;
      tot_d     = '0;
      wd_d      = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (bus.start) begin
            state_d   = ST_SETTLE;
            set_cnt_d = '0;
            run_d     = '0;
            tmo_d     = '0;
            win_d     = bus.window;
            tot_d     = '0;
            wd_d      = '0;
          end else begin
            state_d = state_q;
          end
        end

        ST_SETTLE: begin
          // err_cnt is still reflecting pre-start data while the checker pipeline drains.
          if (set_cnt_q == SET_W'(PIPE_LAT - 1)) begin
            state_d   = ST_LOCK;
            set_cnt_d = '0;
            run_d     = '0;
            tmo_d     = '0;
          end else begin
            set_cnt_d = set_cnt_q + SET_W'(1);
          end
        end

        ST_LOCK: begin
          if (bus.err_cnt == 7'd0) begin
            run_inc = run_q + RUN_W'(1);
          end else begin
            run_inc = '0;
          end
          run_d = run_inc;
          tmo_d = tmo_inc;
          // A run that completes on the timeout word wins over the timeout.
          if (run_inc == RUN_W'(LOCK_WORDS)) begin
            run_d = '0;
            tmo_d = '0;
            if (win_q == '0) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_MEASURE;
            end
          end else if (tmo_inc == TMO_W'(LOCK_TIMEOUT)) begin
            run_d   = '0;
            tmo_d   = '0;
            state_d = ST_FAIL;
          end else begin
            state_d = ST_LOCK;
          end
        end

        ST_MEASURE: begin
          tot_d = sat_add(tot_q, clamp_err(bus.err_cnt));
          wd_d  = wd_inc;
`ifdef PRBS7_BER_LOSS_DETECT_EN
          if (bus.err_cnt >= 7'd32) begin
            state_d = ST_FAIL;
          end else if (wd_inc == win_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_MEASURE;
          end
`else
          if (wd_inc == win_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_MEASURE;
          end
`endif
        end

        default: begin
          state_d   = ST_IDLE;
          set_cnt_d = '0;
          run_d     = '0;
          tmo_d     = '0;
          win_d     = '0;
          tot_d     = '0;
          wd_d      = '0;
        end
      endcase
    end
  end

  // Status flags decoded from the next state so they are registered alongside it.
  always_comb begin
    busy_d   = 1'b0;
    locked_d = 1'b0;
    done_d   = 1'b0;
    fail_d   = 1'b0;
    case (state_d)
      ST_SETTLE, ST_LOCK: begin
        busy_d = 1'b1;
      end
      ST_MEASURE: begin
        busy_d   = 1'b1;
        locked_d = 1'b1;
      end
      ST_DONE: begin
        locked_d = 1'b1;
        done_d   = 1'b1;
      end
      ST_FAIL: begin
        fail_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      set_cnt_q <= '0;
      run_q     <= '0;
      tmo_q     <= '0;
      win_q     <= '0;
      tot_q     <= '0;
      wd_q      <= '0;
      busy_q    <= 1'b0;
      locked_q  <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      set_cnt_q <= set_cnt_d;
      run_q     <= run_d;
      tmo_q     <= tmo_d;
      win_q     <= win_d;
      tot_q     <= tot_d;
      wd_q      <= wd_d;
      busy_q    <= busy_d;
      locked_q  <= locked_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.locked     = locked_q;
  assign bus.done       = done_q;
  assign bus.fail       = fail_q;
  assign bus.state      = state_q;
  assign bus.err_total  = tot_q;
  assign bus.words_done = wd_q;

endmodule
